// File: rtl/sap1_controlador_sequenciador_if.sv
// rtl/sap1_controlador_sequenciador_if.sv - SAP-1 controller opcode/step inputs and control-word outputs
interface sap1_controlador_sequenciador_if;
  logic [3:0] ir_op;
  logic       manual;
  logic       step;
  logic [5:0] t_state;
  logic       cp;
  logic       ep;
  logic       lm;
  logic       ce;
  logic       li;
  logic       ei;
  logic       la;
  logic       ea;
  logic       su;
  logic       eu;
  logic       lb;
  logic       lo;
  logic       hlt;

  modport master (
    input  ir_op, manual, step,
    output t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt
  );

  modport slave (
    output ir_op, manual, step,
    input  t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt
  );
endinterface

// File: rtl/sap1_controlador_sequenciador.sv
// rtl/sap1_controlador_sequenciador.sv - SAP-1 one-hot T-state ring and control-word decoder
module sap1_controlador_sequenciador #(
  parameter logic [3:0] OP_LDA    = 4'b0000,
  parameter logic [3:0] OP_ADD    = 4'b0001,
  parameter logic [3:0] OP_SUB    = 4'b0010,
  parameter logic [3:0] OP_OUT    = 4'b1110,
  parameter logic [3:0] OP_HLT    = 4'b1111,
  parameter bit         SKIP_IDLE = 1'b0
) (
  input  logic                                clk,
  input  logic                                clr_n,
  sap1_controlador_sequenciador_if.master     bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e t_q, t_d;
  logic    halted_q, halted_d;
  logic    step_q;

  logic advance;
  logic is_lda, is_add, is_sub, is_out, is_hlt, is_mem;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

  assign is_lda = (bus.ir_op == OP_LDA);
  assign is_add = (bus.ir_op == OP_ADD);
  assign is_sub = (bus.ir_op == OP_SUB);
  assign is_out = (bus.ir_op == OP_OUT);
  assign is_hlt = (bus.ir_op == OP_HLT);
  assign is_mem = is_lda | is_add | is_sub;

  // In manual mode only the press edge advances, so a held button is one step.
  assign advance = bus.manual ? (bus.step & ~step_q) : 1'b1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      t_q      <= T1;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
      step_q   <= bus.step;
    end
  end

  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
    la = 1'b0; ea = 1'b0; su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;

    if (!halted_q && advance) begin
      unique case (t_q)
        T1: t_d = T2;
        T2: t_d = T3;
        T3: t_d = T4;
        T4: begin
          if (is_hlt)
            halted_d = 1'b1;
          else if (SKIP_IDLE && !is_mem)
            t_d = T1;
          else
            t_d = T5;
        end
        T5: t_d = T6;
        T6: t_d = T1;
        default: t_d = T1;
      endcase
    end

    // Gating on clr_n keeps the bus quiet while reset is held, not just after it.
    if (clr_n && !halted_q) begin
      unique case (t_q)
        T1: begin ep = 1'b1; lm = 1'b1; end
        T2: cp = 1'b1;
        T3: begin ce = 1'b1; li = 1'b1; end
        T4: begin
          if (is_mem) begin
            ei = 1'b1; lm = 1'b1;
          end else if (is_out) begin
            ea = 1'b1; lo = 1'b1;
          end
        end
        T5: begin
          if (is_lda) begin
            ce = 1'b1; la = 1'b1;
          end else if (is_add || is_sub) begin
            ce = 1'b1; lb = 1'b1;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            eu = 1'b1; la = 1'b1; su = is_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.t_state = t_q;
  assign bus.hlt     = halted_q & clr_n;
  assign bus.cp      = cp;
  assign bus.ep      = ep;
  assign bus.lm      = lm;
  assign bus.ce      = ce;
  assign bus.li      = li;
  assign bus.ei      = ei;
  assign bus.la      = la;
  assign bus.ea      = ea;
  assign bus.su      = su;
  assign bus.eu      = eu;
  assign bus.lb      = lb;
  assign bus.lo      = lo;

endmodule

// File: tb/tb_sap1_controlador_sequenciador.sv
// tb/tb_sap1_controlador_sequenciador.sv - directed bench for the SAP-1 controller-sequencer
module tb_sap1_controlador_sequenciador;

  localparam logic [11:0] C_CP = 12'h800;
  localparam logic [11:0] C_EP = 12'h400;
  localparam logic [11:0] C_LM = 12'h200;
  localparam logic [11:0] C_CE = 12'h100;
  localparam logic [11:0] C_LI = 12'h080;
  localparam logic [11:0] C_EI = 12'h040;
  localparam logic [11:0] C_LA = 12'h020;
  localparam logic [11:0] C_EA = 12'h010;
  localparam logic [11:0] C_SU = 12'h008;
  localparam logic [11:0] C_EU = 12'h004;
  localparam logic [11:0] C_LB = 12'h002;
  localparam logic [11:0] C_LO = 12'h001;

  logic clk;
  logic clr_n;
  int   n_vec;
  int   n_err;

  sap1_controlador_sequenciador_if ifa ();
  sap1_controlador_sequenciador_if ifb ();

  sap1_controlador_sequenciador #(.SKIP_IDLE(1'b0)) dut_a (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifa.master)
  );

  sap1_controlador_sequenciador #(.SKIP_IDLE(1'b1)) dut_b (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ctl_a();
    return {ifa.cp, ifa.ep, ifa.lm, ifa.ce, ifa.li, ifa.ei,
            ifa.la, ifa.ea, ifa.su, ifa.eu, ifa.lb, ifa.lo};
  endfunction

  function automatic logic [11:0] ctl_b();
    return {ifb.cp, ifb.ep, ifb.lm, ifb.ce, ifb.li, ifb.ei,
            ifb.la, ifb.ea, ifb.su, ifb.eu, ifb.lb, ifb.lo};
  endfunction

  function automatic int drivers_a();
    return int'(ifa.ep) + int'(ifa.ce) + int'(ifa.ei) + int'(ifa.ea) + int'(ifa.eu);
  endfunction

  task automatic set_inputs(input logic [3:0] op, input logic man, input logic stp);
    ifa.ir_op = op; ifa.manual = man; ifa.step = stp;
    ifb.ir_op = op; ifb.manual = man; ifb.step = stp;
  endtask

  // Leaves the bench 1 time unit after a negedge release, still in T1.
  task automatic do_reset(input logic [3:0] op, input logic man);
    @(negedge clk);
    clr_n = 1'b0;
    set_inputs(op, man, 1'b0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    #1;
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr_n = 1'b0;
    set_inputs(4'b0001, 1'b0, 1'b1);
    #1;
    n_vec++; if (ifa.t_state !== 6'b000001) begin n_err++; $display("FAIL reset_t_state: got %b expected %b", ifa.t_state, 6'b000001); end
    n_vec++; if (ctl_a() !== 12'h000) begin n_err++; $display("FAIL reset_ctl: got %h expected %h", ctl_a(), 12'h000); end
    n_vec++; if (ifa.hlt !== 1'b0) begin n_err++; $display("FAIL reset_hlt: got %b expected 0", ifa.hlt); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (ifb.t_state !== 6'b000001) begin n_err++; $display("FAIL reset_hold_t_state: got %b expected %b", ifb.t_state, 6'b000001); end
    n_vec++; if (ctl_b() !== 12'h000) begin n_err++; $display("FAIL reset_hold_ctl: got %h expected %h", ctl_b(), 12'h000); end
  endtask

  task automatic test_lda_sequence();
    logic [11:0] exp_ctl [6];
    exp_ctl[0] = C_EP | C_LM;
    exp_ctl[1] = C_CP;
    exp_ctl[2] = C_CE | C_LI;
    exp_ctl[3] = C_EI | C_LM;
    exp_ctl[4] = C_CE | C_LA;
    exp_ctl[5] = 12'h000;
    do_reset(4'b0000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      n_vec++; if (ifa.t_state !== 6'(1 << k)) begin n_err++; $display("FAIL lda_t_state cyc%0d: got %b expected %b", k, ifa.t_state, 6'(1 << k)); end
      n_vec++; if (ctl_a() !== exp_ctl[k]) begin n_err++; $display("FAIL lda_ctl cyc%0d: got %h expected %h", k, ctl_a(), exp_ctl[k]); end
      step_edge();
    end
    n_vec++; if (ifa.t_state !== 6'b000001) begin n_err++; $display("FAIL lda_wrap: got %b expected %b", ifa.t_state, 6'b000001); end
  endtask

  task automatic test_sub_free_run();
    do_reset(4'b0010, 1'b0);
    for (int k = 0; k < 12; k++) begin
      n_vec++; if (ifa.t_state !== 6'(1 << (k % 6))) begin n_err++; $display("FAIL sub_t_state cyc%0d: got %b expected %b", k, ifa.t_state, 6'(1 << (k % 6))); end
      n_vec++; if (drivers_a() > 1) begin n_err++; $display("FAIL sub_bus_drivers cyc%0d: got %0d expected <=1", k, drivers_a()); end
      if (k % 6 == 4) begin
        n_vec++; if (ctl_a() !== (C_CE | C_LB)) begin n_err++; $display("FAIL sub_t5_ctl cyc%0d: got %h expected %h", k, ctl_a(), C_CE | C_LB); end
      end
      if (k % 6 == 5) begin
        n_vec++; if (ctl_a() !== (C_EU | C_LA | C_SU)) begin n_err++; $display("FAIL sub_t6_ctl cyc%0d: got %h expected %h", k, ctl_a(), C_EU | C_LA | C_SU); end
      end
      step_edge();
    end
  endtask

  task automatic test_halt();
    do_reset(4'b1111, 1'b0);
    repeat (3) step_edge();
    n_vec++; if (ifa.t_state !== 6'b001000) begin n_err++; $display("FAIL hlt_t4_state: got %b expected %b", ifa.t_state, 6'b001000); end
    n_vec++; if (ctl_a() !== 12'h000) begin n_err++; $display("FAIL hlt_t4_ctl: got %h expected %h", ctl_a(), 12'h000); end
    n_vec++; if (ifa.hlt !== 1'b0) begin n_err++; $display("FAIL hlt_t4_hlt: got %b expected 0", ifa.hlt); end
    step_edge();
    for (int k = 0; k < 20; k++) begin
      n_vec++; if (ifa.t_state !== 6'b001000) begin n_err++; $display("FAIL hlt_frozen_state cyc%0d: got %b expected %b", k, ifa.t_state, 6'b001000); end
      n_vec++; if (ifa.hlt !== 1'b1) begin n_err++; $display("FAIL hlt_flag cyc%0d: got %b expected 1", k, ifa.hlt); end
      n_vec++; if (ctl_a() !== 12'h000) begin n_err++; $display("FAIL hlt_ctl cyc%0d: got %h expected %h", k, ctl_a(), 12'h000); end
      ifa.manual = k[2];
      ifa.step   = k[0];
      step_edge();
    end
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    n_vec++; if (ifa.t_state !== 6'b000001) begin n_err++; $display("FAIL hlt_clr_state: got %b expected %b", ifa.t_state, 6'b000001); end
    n_vec++; if (ifa.hlt !== 1'b0) begin n_err++; $display("FAIL hlt_clr_hlt: got %b expected 0", ifa.hlt); end
  endtask

  task automatic test_manual_step();
    do_reset(4'b0000, 1'b1);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      ifa.step = 1'b1;
      repeat (5) @(negedge clk);
      n_vec++; if (ifa.t_state !== 6'(1 << (p + 1))) begin n_err++; $display("FAIL manual_held press%0d: got %b expected %b", p, ifa.t_state, 6'(1 << (p + 1))); end
      ifa.step = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (ifa.t_state !== 6'(1 << (p + 1))) begin n_err++; $display("FAIL manual_released press%0d: got %b expected %b", p, ifa.t_state, 6'(1 << (p + 1))); end
    end
    n_vec++; if (ctl_a() !== (C_EI | C_LM)) begin n_err++; $display("FAIL manual_t4_ctl: got %h expected %h", ctl_a(), C_EI | C_LM); end
    // Switching to auto while the button is still down must not add an extra step.
    ifa.step = 1'b1;
    @(negedge clk);
    n_vec++; if (ifa.t_state !== 6'b010000) begin n_err++; $display("FAIL manual_press4: got %b expected %b", ifa.t_state, 6'b010000); end
    ifa.manual = 1'b0;
    @(negedge clk);
    n_vec++; if (ifa.t_state !== 6'b100000) begin n_err++; $display("FAIL manual_to_auto: got %b expected %b", ifa.t_state, 6'b100000); end
  endtask

  task automatic test_skip_idle();
    logic [11:0] exp_out [4];
    exp_out[0] = C_EP | C_LM;
    exp_out[1] = C_CP;
    exp_out[2] = C_CE | C_LI;
    exp_out[3] = C_EA | C_LO;
    do_reset(4'b1110, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (ifb.t_state !== 6'(1 << k)) begin n_err++; $display("FAIL skip_out_state cyc%0d: got %b expected %b", k, ifb.t_state, 6'(1 << k)); end
      n_vec++; if (ctl_b() !== exp_out[k]) begin n_err++; $display("FAIL skip_out_ctl cyc%0d: got %h expected %h", k, ctl_b(), exp_out[k]); end
      step_edge();
    end
    n_vec++; if (ifb.t_state !== 6'b000001) begin n_err++; $display("FAIL skip_out_wrap: got %b expected %b", ifb.t_state, 6'b000001); end
    n_vec++; if (ifa.t_state !== 6'b010000) begin n_err++; $display("FAIL noskip_out_t5: got %b expected %b", ifa.t_state, 6'b010000); end
    do_reset(4'b0111, 1'b0);
    repeat (3) step_edge();
    n_vec++; if (ctl_b() !== 12'h000) begin n_err++; $display("FAIL skip_nop_t4_ctl: got %h expected %h", ctl_b(), 12'h000); end
    step_edge();
    n_vec++; if (ifb.t_state !== 6'b000001) begin n_err++; $display("FAIL skip_nop_wrap: got %b expected %b", ifb.t_state, 6'b000001); end
    do_reset(4'b0001, 1'b0);
    repeat (5) step_edge();
    n_vec++; if (ifb.t_state !== 6'b100000) begin n_err++; $display("FAIL skip_add_t6: got %b expected %b", ifb.t_state, 6'b100000); end
    n_vec++; if (ctl_b() !== (C_EU | C_LA)) begin n_err++; $display("FAIL skip_add_t6_ctl: got %h expected %h", ctl_b(), C_EU | C_LA); end
  endtask

  task automatic test_reset_mid_t5();
    do_reset(4'b0001, 1'b0);
    repeat (4) step_edge();
    n_vec++; if (ctl_a() !== (C_CE | C_LB)) begin n_err++; $display("FAIL add_t5_ctl: got %h expected %h", ctl_a(), C_CE | C_LB); end
    #2;
    clr_n = 1'b0;
    #1;
    n_vec++; if (ifa.t_state !== 6'b000001) begin n_err++; $display("FAIL async_clr_state: got %b expected %b", ifa.t_state, 6'b000001); end
    n_vec++; if (ctl_a() !== 12'h000) begin n_err++; $display("FAIL async_clr_ctl: got %h expected %h", ctl_a(), 12'h000); end
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    n_vec++; if (ctl_a() !== (C_EP | C_LM)) begin n_err++; $display("FAIL post_clr_t1_ctl: got %h expected %h", ctl_a(), C_EP | C_LM); end
    step_edge();
    n_vec++; if (ifa.t_state !== 6'b000010) begin n_err++; $display("FAIL post_clr_t2: got %b expected %b", ifa.t_state, 6'b000010); end
    n_vec++; if (ctl_a() !== C_CP) begin n_err++; $display("FAIL post_clr_t2_ctl: got %h expected %h", ctl_a(), C_CP); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr_n = 1'b0;
    set_inputs(4'b0000, 1'b0, 1'b0);
    test_reset();
    test_lda_sequence();
    test_sub_free_run();
    test_halt();
    test_manual_step();
    test_skip_idle();
    test_reset_mid_t5();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
